// File: rtl/memory_access_unit_if.sv
// Request/response bus between the CPU load/store stage and the memory access unit.
// The CPU side is the master; the memory access unit is the slave.
interface memory_access_unit_if;
    logic        start;
    logic        is_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] read_data;

    // start is a strobe sampled only while the unit is idle; done pulses once per
    // accepted request and qualifies error/read_data, which then hold until the next start.
    modport master (
        output start, is_write, funct3, address, write_data,
        input  busy, done, error, read_data
    );

    modport slave (
        input  start, is_write, funct3, address, write_data,
        output busy, done, error, read_data
    );
endinterface

// File: rtl/memory_access_unit.sv
// Splits one byte/halfword/word load or store into little-endian single-byte RAM
// accesses, one per clock, and assembles/extends load data with error reporting.
module memory_access_unit #(
    parameter bit CHECK_ALIGNMENT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    memory_access_unit_if.slave bus,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_output_enable,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_illegal_address,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  count;
    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_data;
    logic [31:0] load_buf;
    logic        error_r;
    logic [31:0] read_data_r;

    logic        req_misaligned;
    logic        req_invalid;
    logic [1:0]  last_index;
    logic        last_byte;
    logic [31:0] merged;
    logic [7:0]  store_byte;

    // Request qualification, evaluated on the live bus while idle.
    always_comb begin
        req_misaligned = 1'b0;
        if (bus.funct3[1:0] == 2'b01) begin
            req_misaligned = bus.address[0];
        end else if (bus.funct3[1:0] == 2'b10) begin
            req_misaligned = (bus.address[1:0] != 2'b00);
        end
        req_invalid = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                      (bus.funct3 == 3'b111) ||
                      (bus.is_write && bus.funct3[2]) ||
                      (CHECK_ALIGNMENT && req_misaligned);
    end

    always_comb begin
        case (lat_funct3[1:0])
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
        last_byte  = (count == last_index);
        store_byte = lat_data[{count, 3'b000} +: 8];
        merged     = load_buf;
        merged[{count, 3'b000} +: 8] = mem_read_data;
    end

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b100:  extend = {24'h0, w[7:0]};
            3'b101:  extend = {16'h0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enables are combinational from state; reset masks them so an aborted store
    // cannot write in the cycle reset is sampled.
    always_comb begin
        state_next        = state;
        mem_write_enable  = 1'b0;
        mem_output_enable = 1'b0;
        mem_write_data    = 8'h00;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = req_invalid ? FINISH : ACCESS;
                end
            end
            ACCESS: begin
                mem_output_enable = !lat_write;
                mem_write_enable  = lat_write && !mem_illegal_address;
                mem_write_data    = lat_write ? store_byte : 8'h00;
                if (mem_illegal_address || last_byte) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            mem_write_enable  = 1'b0;
            mem_output_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= 2'd0;
            lat_write   <= 1'b0;
            lat_funct3  <= 3'b000;
            lat_data    <= 32'h0;
            load_buf    <= 32'h0;
            error_r     <= 1'b0;
            read_data_r <= 32'h0;
            mem_address <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lat_write   <= bus.is_write;
                        lat_funct3  <= bus.funct3;
                        lat_data    <= bus.write_data;
                        count       <= 2'd0;
                        load_buf    <= 32'h0;
                        read_data_r <= 32'h0;
                        error_r     <= req_invalid;
                        // Rejected requests never touch memory, so the address bus keeps its value.
                        if (!req_invalid) begin
                            mem_address <= bus.address;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_illegal_address) begin
                        error_r <= 1'b1;
                    end else begin
                        if (!lat_write) begin
                            load_buf <= merged;
                        end
                        if (last_byte) begin
                            read_data_r <= lat_write ? 32'h0 : extend(lat_funct3, merged);
                        end else begin
                            count       <= count + 2'd1;
                            mem_address <= mem_address + 32'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign bus.error     = error_r;
    assign bus.read_data = read_data_r;
    assign debug_state   = state;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: two instances (alignment checked / unchecked) share one
// byte RAM model; every request is predicted by a request-level reference model.
module tb_memory_access_unit;

    logic clk;
    logic reset;
    logic sel;
    logic init_en;

    memory_access_unit_if if0 ();
    memory_access_unit_if if1 ();

    logic [31:0] ma0, ma1;
    logic [7:0]  mwd0, mwd1;
    logic        mwe0, mwe1, moe0, moe1;
    logic [1:0]  dbg0, dbg1;
    logic [7:0]  mem_read_data;
    logic        mem_illegal_address;

    memory_access_unit #(.CHECK_ALIGNMENT(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(if0),
        .mem_address(ma0), .mem_write_data(mwd0), .mem_write_enable(mwe0),
        .mem_output_enable(moe0), .mem_read_data(mem_read_data),
        .mem_illegal_address(mem_illegal_address), .debug_state(dbg0)
    );

    memory_access_unit #(.CHECK_ALIGNMENT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .mem_address(ma1), .mem_write_data(mwd1), .mem_write_enable(mwe1),
        .mem_output_enable(moe1), .mem_read_data(mem_read_data),
        .mem_illegal_address(mem_illegal_address), .debug_state(dbg1)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared RAM, 0x0000..0x1FFF, combinational read
    logic [7:0]  ram [0:8191];
    logic [39:0] act_q[$];
    logic [31:0] m_addr;
    logic [7:0]  m_wd;
    logic        m_we, m_oe, m_busy, m_done, m_err;
    logic [31:0] m_rdata;

    assign m_addr  = sel ? ma1  : ma0;
    assign m_wd    = sel ? mwd1 : mwd0;
    assign m_we    = sel ? mwe1 : mwe0;
    assign m_oe    = sel ? moe1 : moe0;
    assign m_busy  = sel ? if1.busy : if0.busy;
    assign m_done  = sel ? if1.done : if0.done;
    assign m_err   = sel ? if1.error : if0.error;
    assign m_rdata = sel ? if1.read_data : if0.read_data;
    assign mem_illegal_address = (m_addr > 32'h1FFF);
    assign mem_read_data = mem_illegal_address ? 8'h00 : ram[m_addr[12:0]];

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            32'h100: return 8'h80;
            32'h101: return 8'h12;
            32'h102: return 8'h34;
            32'h103: return 8'hF6;
            default: return 8'(i * 37 + 5);
        endcase
    endfunction

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 8192; i++) ram[i] <= init_byte(i);
        end else if (m_we) begin
            ram[m_addr[12:0]] <= m_wd;
            act_q.push_back({m_addr, m_wd});
        end
    end

    // Scoreboard state
    logic [7:0]  ref_mem [0:8191];
    logic [39:0] exp_q[$];
    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-request outcome from the access rules.
    task automatic model(input bit align, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output bit err, output logic [31:0] rd,
                         output bit access);
        int n;
        longint v;
        logic [31:0] ad;
        logic [7:0] b [4];
        exp_q.delete();
        for (int k = 0; k < 4; k++) b[k] = 8'h00;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        err = 1'b0;
        rd = 32'h0;
        access = 1'b0;
        lat = 1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (w && f3 >= 3'd4) ||
            (align && (a % 32'(n)) != 0)) begin
            err = 1'b1;
            return;
        end
        access = 1'b1;
        for (int k = 0; k < n; k++) begin
            ad = a + 32'(k);
            if (ad > 32'h1FFF) begin
                err = 1'b1;
                lat = k + 2;
                return;
            end
            if (w) begin
                exp_q.push_back({ad, wd[8*k +: 8]});
                ref_mem[ad[12:0]] = wd[8*k +: 8];
            end else begin
                b[k] = ref_mem[ad[12:0]];
            end
        end
        lat = n + 1;
        if (!w) begin
            v = longint'(b[0]) + 256 * longint'(b[1]) + 65536 * longint'(b[2]) +
                16777216 * longint'(b[3]);
            if (f3 == 3'b000 && v >= 128) v = v - 256;
            if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            rd = v[31:0];
        end
    endtask

    // Driver tasks
    task automatic drive_req(input bit st, input bit w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        if0.start = st & ~sel;   if1.start = st & sel;
        if0.is_write = w;        if1.is_write = w;
        if0.funct3 = f3;         if1.funct3 = f3;
        if0.address = a;         if1.address = a;
        if0.write_data = wd;     if1.write_data = wd;
    endtask

    task automatic do_req(input string tag, input bit s, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int lat, cyc, done_cyc, base, nact;
        bit err, access, oe_seen, busy_bad;
        logic [31:0] rd;
        model(!s, w, f3, a, wd, lat, err, rd, access);
        base = act_q.size();
        @(negedge clk);
        sel = s;
        drive_req(1'b1, w, f3, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc = 1; done_cyc = 0; oe_seen = 0; busy_bad = 0;
        while (cyc <= 20 && done_cyc == 0) begin
            if (m_oe === 1'b1) oe_seen = 1;
            if (m_busy !== 1'b1) busy_bad = 1;
            if (m_done === 1'b1) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(lat));
        chk({tag, " error"}, 64'(m_err), 64'(err));
        chk({tag, " read_data"}, 64'(m_rdata), 64'(rd));
        chk({tag, " busy_span"}, 64'(busy_bad), 64'd0);
        chk({tag, " oe_seen"}, 64'(oe_seen), 64'(access && !w));
        nact = act_q.size() - base;
        chk({tag, " write_count"}, 64'(nact), 64'(exp_q.size()));
        for (int i = 0; i < nact && i < exp_q.size(); i++)
            chk({tag, " write"}, 64'(act_q[base + i]), 64'(exp_q[i]));
        @(negedge clk);
        chk({tag, " done_after"}, 64'(m_done), 64'd0);
        chk({tag, " busy_after"}, 64'(m_busy), 64'd0);
    endtask

    initial begin
        int base, ndone, second_done, bad;
        logic [2:0] f3;
        logic [31:0] a;
        checks = 0;
        errors = 0;
        sel = 1'b0;
        init_en = 1'b1;
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst busy", 64'(if0.busy), 64'd0);
        chk("rst done", 64'(if0.done), 64'd0);
        chk("rst error", 64'(if0.error), 64'd0);
        chk("rst read_data", 64'(if0.read_data), 64'd0);
        chk("rst mem_address", 64'(ma0), 64'd0);
        chk("rst enables", 64'({mwe0, moe0, mwd0}), 64'd0);
        chk("rst state", 64'(dbg0), 64'd0);

        // Directed loads from the preloaded window
        do_req("lw_100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_100 const", 64'(if0.read_data), 64'hF6341280);
        do_req("lb_100", 1'b0, 1'b0, 3'b000, 32'h100, 32'h0);
        do_req("lbu_100", 1'b0, 1'b0, 3'b100, 32'h100, 32'h0);
        do_req("lh_102", 1'b0, 1'b0, 3'b001, 32'h102, 32'h0);
        do_req("lhu_102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0);

        // Store then read back
        do_req("sw_200", 1'b0, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF);
        do_req("lw_200", 1'b0, 1'b0, 3'b010, 32'h200, 32'h0);
        chk("lw_200 const", 64'(if0.read_data), 64'hDEADBEEF);

        // Rejections and range errors
        do_req("lw_101_mis", 1'b0, 1'b0, 3'b010, 32'h101, 32'h0);
        do_req("sh_103_mis", 1'b0, 1'b1, 3'b001, 32'h103, 32'h1234);
        do_req("sw_2000", 1'b0, 1'b1, 3'b010, 32'h2000, 32'h11223344);
        do_req("sw_1ffe_noalign", 1'b1, 1'b1, 3'b010, 32'h1FFE, 32'hA1B2C3D4);
        do_req("lw_101_noalign", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        do_req("f3_011", 1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
        do_req("sbu_illegal", 1'b1, 1'b1, 3'b100, 32'h100, 32'h55);

        // Reset in the second ACCESS cycle of SW 0x300
        base = act_q.size();
        @(negedge clk);
        sel = 1'b0;
        drive_req(1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_mem[32'h300] = 8'h0D;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (if0.done === 1'b1 || if0.busy === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("rst_abort activity", 64'(ndone), 64'd0);
        chk("rst_abort write_count", 64'(act_q.size() - base), 64'd1);
        if (act_q.size() > base)
            chk("rst_abort write", 64'(act_q[base]), 64'({32'h300, 8'h0D}));
        chk("rst_abort ram_301", 64'(ram[13'h301]), 64'(ref_mem[13'h301]));
        do_req("after_rst", 1'b0, 1'b0, 3'b010, 32'h300, 32'h0);

        // start held high: accepted only in IDLE cycles
        @(negedge clk);
        sel = 1'b0;
        drive_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        @(posedge clk);
        ndone = 0;
        second_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 12) drive_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            if (if0.done === 1'b1) begin
                ndone++;
                if (ndone == 2) second_done = c;
            end
        end
        chk("held_start done_pulses", 64'(ndone), 64'd2);
        chk("held_start second_done", 64'(second_done), 64'd11);
        chk("held_start read_data", 64'(if0.read_data), 64'hF6341280);

        // Randomized requests against the reference model
        for (int t = 0; t < 40; t++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: a = 32'h000 + 32'($urandom_range(0, 255));
                1: a = 32'h1FF8 + 32'($urandom_range(0, 12));
                default: a = 32'h400 + 32'($urandom_range(0, 63));
            endcase
            do_req("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        bad = 0;
        for (int i = 0; i < 8192; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_image", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
